// File: rtl/dram_refresh_pkg.sv
// Shared DRAM refresh constants and the pending-counter width helper.
package dram_refresh_pkg;

    localparam int unsigned TREFI_DEFAULT    = 1170;  // 7.8 us at 150 MHz
    localparam int unsigned MAX_POSTPONE_DDR = 8;

    function automatic int unsigned pend_width(input int unsigned max_postpone);
        return $clog2(max_postpone + 1);
    endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Command-scheduler side bundle of the refresh scheduler: config, per-rank req/ack, status.
interface refresh_scheduler_if
    import dram_refresh_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned NUM_RANKS = 2,
    parameter int unsigned PEND_W    = pend_width(MAX_POSTPONE_DDR)
);

    logic                        en;
    logic [CNT_W-1:0]            cfg_trefi;
    logic [NUM_RANKS-1:0]        ref_ack;
    logic [NUM_RANKS-1:0]        ref_req;
    logic [NUM_RANKS-1:0]        ref_urgent;
    logic [NUM_RANKS*PEND_W-1:0] pending_cnt;
    logic                        tick;
    logic                        overflow_err;

    modport master (
        output en, cfg_trefi, ref_ack,
        input  ref_req, ref_urgent, pending_cnt, tick, overflow_err
    );

    modport slave (
        input  en, cfg_trefi, ref_ack,
        output ref_req, ref_urgent, pending_cnt, tick, overflow_err
    );

endinterface

// File: rtl/refresh_credit.sv
// One rank's owed-refresh counter: saturating increment on tick, qualified decrement on ack.
module refresh_credit
    import dram_refresh_pkg::*;
#(
    parameter int unsigned MAX_POSTPONE  = MAX_POSTPONE_DDR,
    parameter int unsigned URGENT_THRESH = 6,
    parameter int unsigned PEND_W        = pend_width(MAX_POSTPONE)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_tick,
    input  logic              i_ack,
    output logic [PEND_W-1:0] o_pend,
    output logic              o_req,
    output logic              o_urgent,
    output logic              o_ovf_c
);

    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              w_ack_ok;
    logic              w_at_max;

    assign w_ack_ok = i_ack && (r_pend != '0);
    assign w_at_max = (r_pend == PEND_W'(MAX_POSTPONE));

    // A tick and a valid ack on the same edge cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        o_ovf_c    = 1'b0;
        if (i_tick && !w_ack_ok) begin
            if (w_at_max) begin
                o_ovf_c = 1'b1;
            end else begin
                w_pend_nxt = r_pend + PEND_W'(1);
            end
        end else if (!i_tick && w_ack_ok) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign o_pend   = r_pend;
    assign o_req    = (r_pend != '0);
    assign o_urgent = (r_pend >= PEND_W'(URGENT_THRESH));

endmodule

// File: rtl/refresh_scheduler.sv
// tREFI interval timer feeding per-rank refresh credit counters, with sticky overflow.
module refresh_scheduler
    import dram_refresh_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned NUM_RANKS     = 2,
    parameter int unsigned MAX_POSTPONE  = MAX_POSTPONE_DDR,
    parameter int unsigned URGENT_THRESH = 6,
    parameter int unsigned PEND_W        = pend_width(MAX_POSTPONE)
) (
    input  logic                clk,
    input  logic                rst_b,
    refresh_scheduler_if.slave  bus
);

    logic [CNT_W-1:0]            r_count;
    logic                        r_tick;
    logic                        r_overflow;
    logic                        w_trefi_on;
    logic                        w_wrap;
    logic [NUM_RANKS-1:0]        w_ovf;
    logic [NUM_RANKS-1:0]        w_req;
    logic [NUM_RANKS-1:0]        w_urgent;
    logic [NUM_RANKS*PEND_W-1:0] w_pend;

    // >= rather than == so a shrunk interval wraps immediately instead of rolling over.
    assign w_trefi_on = (bus.cfg_trefi != '0);
    assign w_wrap     = bus.en && w_trefi_on && (r_count >= (bus.cfg_trefi - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (bus.en) begin
                if (!w_trefi_on || w_wrap) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_RANKS); g++) begin : g_rank
        refresh_credit #(
            .MAX_POSTPONE  (MAX_POSTPONE),
            .URGENT_THRESH (URGENT_THRESH),
            .PEND_W        (PEND_W)
        ) u_credit (
            .clk      (clk),
            .rst_b    (rst_b),
            .i_tick   (w_wrap),
            .i_ack    (bus.ref_ack[g]),
            .o_pend   (w_pend[g*PEND_W +: PEND_W]),
            .o_req    (w_req[g]),
            .o_urgent (w_urgent[g]),
            .o_ovf_c  (w_ovf[g])
        );
    end

    // Sticky until reset: any rank dropping a tick at saturation.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (|w_ovf);
        end
    end

    assign bus.tick         = r_tick;
    assign bus.overflow_err = r_overflow;
    assign bus.pending_cnt  = w_pend;
    assign bus.ref_req      = w_req;
    assign bus.ref_urgent   = w_urgent;

endmodule
